// File: rtl/mops_pulse_gen_if.sv
// Configuration, start handshake and sample outputs of the MoPS synthetic pulse generator.
// The generator binds to the slave modport; the source of START and the settings binds to master.
interface mops_pulse_gen_if #(
   parameter int ADC_WIDTH = 12,
   parameter int CNT_WIDTH = 8
);
   logic                 START;
   logic [ADC_WIDTH-1:0] BASELINE;
   logic [ADC_WIDTH-1:0] STEP_AMP;
   logic [3:0]           RISE_SAMPLES;
   logic [2:0]           DECAY_SHIFT;
   logic [CNT_WIDTH-1:0] N_PULSES;
   logic [CNT_WIDTH-1:0] GAP;
   logic [2:0]           PMT_MASK;
   logic [ADC_WIDTH-1:0] ADC0;
   logic [ADC_WIDTH-1:0] ADC1;
   logic [ADC_WIDTH-1:0] ADC2;
   logic                 BUSY;
   logic                 DONE;

   modport master (
      output START, BASELINE, STEP_AMP, RISE_SAMPLES, DECAY_SHIFT,
             N_PULSES, GAP, PMT_MASK,
      input  ADC0, ADC1, ADC2, BUSY, DONE
   );

   modport slave (
      input  START, BASELINE, STEP_AMP, RISE_SAMPLES, DECAY_SHIFT,
             N_PULSES, GAP, PMT_MASK,
      output ADC0, ADC1, ADC2, BUSY, DONE
   );
endinterface

// File: rtl/mops_pulse_gen.sv
// Synthetic three-channel ADC pulse bursts (step rise, exponential decay) on the 40 MHz grid of CLK120.
// Define MOPS_PULSE_GEN_JITTER_EN to add 0-3 samples of LFSR jitter to each pulse spacing.
module mops_pulse_gen #(
   parameter int ADC_WIDTH = 12,
   parameter int CNT_WIDTH = 8
) (
   input  logic       CLK120,
   input  logic       RESET,
   input  logic [1:0] ENABLE40,
   mops_pulse_gen_if.slave bus
);
   localparam int GW = CNT_WIDTH + 2;
   localparam logic [ADC_WIDTH:0] MAX_LVL = {1'b0, {ADC_WIDTH{1'b1}}};

   typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

   state_t               state, state_n;
   logic                 start_pend, start_pend_n;
   logic                 busy_r, busy_n;
   logic                 done_r, done_n;
   logic [ADC_WIDTH:0]   level, level_n;
   logic [CNT_WIDTH-1:0] pulse_cnt, pulse_cnt_n;
   logic [GW-1:0]        gap_cnt, gap_cnt_n;
   logic [3:0]           rise_cnt, rise_cnt_n;
   logic                 begin_pulse;
   logic [ADC_WIDTH-1:0] adc0, adc1, adc2;

   logic                 tick;
   logic [3:0]           rise_eff;
   logic [GW-1:0]        min_gap, base_gap, eff_gap, jitter;
   logic [ADC_WIDTH:0]   rise_sum, level_rise, decay_step, level_decay;

   assign tick        = (ENABLE40 == 2'd2);
   assign rise_eff    = (bus.RISE_SAMPLES == 4'd0) ? 4'd1 : bus.RISE_SAMPLES;
   assign min_gap     = GW'(rise_eff) + GW'(1);
   assign base_gap    = (GW'(bus.GAP) > min_gap) ? GW'(bus.GAP) : min_gap;
   assign eff_gap     = base_gap + jitter;
   assign rise_sum    = level + {1'b0, bus.STEP_AMP};
   assign level_rise  = (rise_sum > MAX_LVL) ? MAX_LVL : rise_sum;
   assign decay_step  = level >> bus.DECAY_SHIFT;
   assign level_decay = (decay_step == '0) ? '0 : level - decay_step;

`ifdef MOPS_PULSE_GEN_JITTER_EN
   logic [15:0] lfsr;

   // Galois LFSR (taps 16,14,13,11) stepped once per 40 MHz sample
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         lfsr <= 16'hACE1;
      end else if (tick) begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign jitter = GW'(lfsr[1:0]);
`else
   assign jitter = '0;
`endif

   function automatic logic [ADC_WIDTH-1:0] chan_out(input logic en,
                                                     input logic [ADC_WIDTH-1:0] base,
                                                     input logic [ADC_WIDTH:0] lvl);
      logic [ADC_WIDTH:0] sum;
      sum = {1'b0, base} + lvl;
      if (!en) return base;
      return (sum > MAX_LVL) ? {ADC_WIDTH{1'b1}} : sum[ADC_WIDTH-1:0];
   endfunction

   // gap_cnt holds the samples left in the current pulse after this one; at zero the
   // next pulse starts (level kept, so pulses may pile up) or the burst ends
   always_comb begin
      state_n      = state;
      start_pend_n = start_pend;
      busy_n       = busy_r;
      done_n       = 1'b0;
      level_n      = level;
      pulse_cnt_n  = pulse_cnt;
      gap_cnt_n    = gap_cnt;
      rise_cnt_n   = rise_cnt;
      begin_pulse  = 1'b0;

      if (bus.START && !busy_r && !done_r && !start_pend) start_pend_n = 1'b1;

      if (tick) begin
         unique case (state)
            IDLE: begin
               level_n = '0;
               if (start_pend) begin
                  start_pend_n = 1'b0;
                  if (bus.N_PULSES == '0) begin
                     done_n = 1'b1;
                  end else begin
                     begin_pulse = 1'b1;
                     pulse_cnt_n = bus.N_PULSES;
                     busy_n      = 1'b1;
                  end
               end
            end
            RISE, DECAY: begin
               if (gap_cnt == '0) begin
                  if (pulse_cnt > CNT_WIDTH'(1)) begin
                     begin_pulse = 1'b1;
                     pulse_cnt_n = pulse_cnt - CNT_WIDTH'(1);
                  end else begin
                     state_n     = IDLE;
                     level_n     = '0;
                     done_n      = 1'b1;
                     busy_n      = 1'b0;
                     pulse_cnt_n = '0;
                     rise_cnt_n  = '0;
                  end
               end else begin
                  gap_cnt_n = gap_cnt - GW'(1);
                  if (state == RISE) begin
                     level_n    = level_rise;
                     rise_cnt_n = rise_cnt - 4'd1;
                     if (rise_cnt == 4'd1) state_n = DECAY;
                  end else begin
                     level_n = level_decay;
                  end
               end
            end
            default: state_n = IDLE;
         endcase

         if (begin_pulse) begin
            level_n    = level_rise;
            gap_cnt_n  = eff_gap - GW'(1);
            rise_cnt_n = rise_eff - 4'd1;
            state_n    = (rise_eff == 4'd1) ? DECAY : RISE;
         end
      end
   end

   always_ff @(posedge CLK120) begin
      if (RESET) begin
         state      <= IDLE;
         start_pend <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         level      <= '0;
         pulse_cnt  <= '0;
         gap_cnt    <= '0;
         rise_cnt   <= '0;
         adc0       <= '0;
         adc1       <= '0;
         adc2       <= '0;
      end else begin
         state      <= state_n;
         start_pend <= start_pend_n;
         busy_r     <= busy_n;
         done_r     <= done_n;
         level      <= level_n;
         pulse_cnt  <= pulse_cnt_n;
         gap_cnt    <= gap_cnt_n;
         rise_cnt   <= rise_cnt_n;
         if (tick) begin
            adc0 <= chan_out(bus.PMT_MASK[0], bus.BASELINE, level_n);
            adc1 <= chan_out(bus.PMT_MASK[1], bus.BASELINE, level_n);
            adc2 <= chan_out(bus.PMT_MASK[2], bus.BASELINE, level_n);
         end
      end
   end

   assign bus.ADC0 = adc0;
   assign bus.ADC1 = adc1;
   assign bus.ADC2 = adc2;
   assign bus.BUSY = busy_r;
   assign bus.DONE = done_r;
endmodule

// File: tb/tb_mops_pulse_gen.sv
// Self-checking bench for mops_pulse_gen: table-driven bursts with hand-computed
// per-sample outputs, plus directed reset / START-handling sequences.
module tb_mops_pulse_gen;
   localparam int AW = 12;
   localparam int CW = 8;
   localparam int NS = 7;
   localparam int NT = 22;

   typedef struct {
      logic [11:0] baseline;
      logic [11:0] step;
      logic [3:0]  rise;
      logic [2:0]  shift;
      logic [7:0]  npulses;
      logic [7:0]  gap;
      logic [2:0]  mask;
      int          nticks;
      int          dtick;
   } scen_t;

   logic       CLK120;
   logic       RESET;
   logic [1:0] ENABLE40;

   int total;
   int bad;

   scen_t tbl[NS];
   int    expv[NS][NT];

   mops_pulse_gen_if #(.ADC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   mops_pulse_gen #(.ADC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .CLK120   (CLK120),
      .RESET    (RESET),
      .ENABLE40 (ENABLE40),
      .bus      (bus)
   );

   // 120 MHz-style clock and the repeating 0,1,2 sample phase, changed 1 ns after each edge
   initial begin
      CLK120 = 1'b0;
      forever #4 CLK120 = ~CLK120;
   end

   initial begin
      ENABLE40 = 2'd0;
      forever begin
         @(posedge CLK120);
         #1 ENABLE40 = (ENABLE40 == 2'd2) ? 2'd0 : ENABLE40 + 2'd1;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // returns 2 ns after the next tick edge, where ENABLE40 has moved back to 0
   task automatic waitTick;
      do @(posedge CLK120); while (ENABLE40 != 2'd2);
      #2;
   endtask

   task automatic pulseStart;
      bus.START = 1'b1;
      @(posedge CLK120);
      #1 bus.START = 1'b0;
   endtask

   task automatic applyStimulus(input scen_t s);
      bus.BASELINE     = s.baseline;
      bus.STEP_AMP     = s.step;
      bus.RISE_SAMPLES = s.rise;
      bus.DECAY_SHIFT  = s.shift;
      bus.N_PULSES     = s.npulses;
      bus.GAP          = s.gap;
      bus.PMT_MASK     = s.mask;
   endtask

   initial begin
      logic [2:0] m;
      int         ev;
      int         act;
      scen_t      s;

      total = 0;
      bad   = 0;
      RESET = 1'b1;
      bus.START = 1'b0;

      tbl[0] = '{12'd50,   12'd20,   4'd3, 3'd0, 8'd2, 8'd10, 3'b101, 22, 20};
      tbl[1] = '{12'd50,   12'd64,   4'd1, 3'd1, 8'd1, 8'd20, 3'b011, 22, 20};
      tbl[2] = '{12'd4000, 12'd2000, 4'd4, 3'd3, 8'd1, 8'd6,  3'b100, 8,  6};
      tbl[3] = '{12'd0,    12'd3000, 4'd2, 3'd1, 8'd1, 8'd4,  3'b001, 6,  4};
      tbl[4] = '{12'd10,   12'd1,    4'd5, 3'd2, 8'd2, 8'd2,  3'b111, 14, 12};
      tbl[5] = '{12'd30,   12'd5,    4'd2, 3'd0, 8'd0, 8'd4,  3'b111, 2,  0};
      tbl[6] = '{12'd0,    12'd100,  4'd0, 3'd0, 8'd1, 8'd1,  3'b001, 4,  2};

      expv[0] = '{70,90,110,50,50,50,50,50,50,50,70,90,110,50,50,50,50,50,50,50,50,50};
      expv[1] = '{114,82,66,58,54,52,51,50,50,50,50,50,50,50,50,50,50,50,50,50,50,50};
      expv[2] = '{4095,4095,4095,4095,4095,4095,4000,4000,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
      expv[3] = '{3000,4095,2048,1024,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
      expv[4] = '{11,12,13,14,15,14,15,16,17,18,19,17,10,10,0,0,0,0,0,0,0,0};
      expv[5] = '{30,30,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
      expv[6] = '{100,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

      // reset state, then BASELINE appears on the first tick after release
      s = '{12'd50, 12'd20, 4'd3, 3'd0, 8'd1, 8'd10, 3'b111, 0, 0};
      applyStimulus(s);
      repeat (4) @(posedge CLK120);
      waitTick;
      RESET = 1'b0;
      @(posedge CLK120);
      #2;
      checkOutput("reset adc0", int'(bus.ADC0), 0);
      checkOutput("reset adc1", int'(bus.ADC1), 0);
      checkOutput("reset adc2", int'(bus.ADC2), 0);
      checkOutput("reset busy", int'(bus.BUSY), 0);
      checkOutput("reset done", int'(bus.DONE), 0);
      waitTick;
      checkOutput("idle adc0", int'(bus.ADC0), 50);
      checkOutput("idle adc1", int'(bus.ADC1), 50);
      checkOutput("idle adc2", int'(bus.ADC2), 50);
      checkOutput("idle busy", int'(bus.BUSY), 0);

      // table-driven bursts: one START, then every tick compared against the hand-computed row
      for (int i = 0; i < NS; i++) begin
         applyStimulus(tbl[i]);
         waitTick;
         pulseStart;
         m = tbl[i].mask;
         for (int t = 0; t < tbl[i].nticks; t++) begin
            waitTick;
            for (int c = 0; c < 3; c++) begin
               ev  = m[c] ? expv[i][t] : int'(tbl[i].baseline);
               act = (c == 0) ? int'(bus.ADC0) : (c == 1) ? int'(bus.ADC1) : int'(bus.ADC2);
               checkOutput($sformatf("s%0d t%0d adc%0d", i, t, c), act, ev);
            end
            checkOutput($sformatf("s%0d t%0d busy", i, t), int'(bus.BUSY),
                        (t < tbl[i].dtick) ? 1 : 0);
            checkOutput($sformatf("s%0d t%0d done", i, t), int'(bus.DONE),
                        (t == tbl[i].dtick) ? 1 : 0);
         end
      end

      // reset in the middle of a rising phase
      s = '{12'd50, 12'd10, 4'd5, 3'd0, 8'd3, 8'd8, 3'b111, 0, 0};
      applyStimulus(s);
      waitTick;
      pulseStart;
      waitTick;
      checkOutput("midrst t0 adc0", int'(bus.ADC0), 60);
      waitTick;
      checkOutput("midrst t1 adc0", int'(bus.ADC0), 70);
      checkOutput("midrst t1 busy", int'(bus.BUSY), 1);
      RESET = 1'b1;
      @(posedge CLK120);
      #2;
      checkOutput("midrst adc0", int'(bus.ADC0), 0);
      checkOutput("midrst adc1", int'(bus.ADC1), 0);
      checkOutput("midrst adc2", int'(bus.ADC2), 0);
      checkOutput("midrst busy", int'(bus.BUSY), 0);
      RESET = 1'b0;
      waitTick;
      checkOutput("postrst adc0", int'(bus.ADC0), 50);
      checkOutput("postrst busy", int'(bus.BUSY), 0);
      waitTick;
      checkOutput("postrst2 busy", int'(bus.BUSY), 0);
      checkOutput("postrst2 adc1", int'(bus.ADC1), 50);

      // START while busy and START during the DONE cycle are both dropped
      s = '{12'd0, 12'd8, 4'd1, 3'd0, 8'd1, 8'd4, 3'b001, 0, 0};
      applyStimulus(s);
      waitTick;
      pulseStart;
      waitTick;
      checkOutput("ign t0 adc0", int'(bus.ADC0), 8);
      pulseStart;
      waitTick;
      checkOutput("ign t1 adc0", int'(bus.ADC0), 0);
      checkOutput("ign t1 busy", int'(bus.BUSY), 1);
      waitTick;
      waitTick;
      waitTick;
      checkOutput("ign t4 done", int'(bus.DONE), 1);
      checkOutput("ign t4 busy", int'(bus.BUSY), 0);
      pulseStart;
      #1;
      checkOutput("ign done width", int'(bus.DONE), 0);
      waitTick;
      checkOutput("ign t5 busy", int'(bus.BUSY), 0);
      checkOutput("ign t5 adc0", int'(bus.ADC0), 0);
      waitTick;
      checkOutput("ign t6 busy", int'(bus.BUSY), 0);
      checkOutput("ign t6 adc0", int'(bus.ADC0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mops_pulse_gen.md
# mops_pulse_gen

Synthetic three-channel ADC pulse generator for the MoPS trigger path. Produces step-shaped pulses with exponential decay on a 40 MHz sample grid inside the 120 MHz domain, so the MoPS trigger and its integral stages can be exercised in-system without PMT signal. Sits in sde_trigger between the ADC front-end multiplexer and the trigger inputs, selected in place of live ADC data when test mode is active.

## Interface
Parameters:
- ADC_WIDTH, 12, width of each ADC sample
- CNT_WIDTH, 8, width of pulse-count and gap counters

Ports:
- CLK120  in  1  120 MHz system clock
- RESET  in  1  synchronous, active-high reset
- ENABLE40  in  2  40 MHz phase (0,1,2 repeating)
- START  in  1  one-cycle request to begin a burst
- BASELINE  in  ADC_WIDTH  pedestal added to every output sample
- STEP_AMP  in  ADC_WIDTH  amplitude added per rising sample
- RISE_SAMPLES  in  4  rising samples per pulse (0 treated as 1)
- DECAY_SHIFT  in  3  decay: level -= level >> DECAY_SHIFT each sample
- N_PULSES  in  CNT_WIDTH  pulses per burst
- GAP  in  CNT_WIDTH  40 MHz samples from one pulse start to the next
- PMT_MASK  in  3  channels that carry pulses; others output BASELINE
- ADC0, ADC1, ADC2  out  ADC_WIDTH  generated samples
- BUSY  out  1  high from burst acceptance until DONE
- DONE  out  1  one CLK120 pulse at burst end

## Operation
- Tick: internal 40 MHz strobe, asserted when ENABLE40 == 2. All state, counters and ADC outputs update only on tick; DONE also asserts on a tick.
- START latched on any CLK120 cycle while BUSY = 0 and not already latched; consumed at next tick. START while BUSY = 1 ignored.
- States: IDLE, RISE, DECAY.
  - IDLE: level = 0. On tick with latched START: if N_PULSES == 0 -> assert DONE, stay IDLE, BUSY never rises; else load pulse counter = N_PULSES, gap counter = eff_gap, rise counter = max(RISE_SAMPLES,1), go RISE, BUSY = 1.
  - RISE: each tick level <= sat(level + STEP_AMP); rise counter decrements; at 1 -> DECAY.
  - DECAY: each tick if (level >> DECAY_SHIFT) == 0 then level <= 0, else level <= level - (level >> DECAY_SHIFT). DECAY_SHIFT = 0 zeroes level in one tick.
  - Gap counter decrements every tick in RISE and DECAY. On the tick it reaches 1: pulse counter decrements; if pulses remain -> reload rise/gap counters, go RISE (level not cleared; pile-up allowed); else -> IDLE, DONE = 1, BUSY = 0, level forced to 0.
- eff_gap = max(GAP, RISE_SAMPLES_eff + 1); rising phase always completes.
- Arithmetic: level held in ADC_WIDTH+1 bits; sat() clamps at 2^ADC_WIDTH − 1. Output = min(BASELINE + level, 2^ADC_WIDTH − 1) for channels with PMT_MASK bit set, BASELINE otherwise.
- Config inputs sampled live each tick except N_PULSES (sampled at burst start).
- RESET mid-burst: immediate return to IDLE, latched START cleared, counters 0.

## Timing
- Reset values: ADC0..2 = 0, BUSY = 0, DONE = 0, level = 0, state IDLE.
- After reset, outputs become BASELINE at first tick.
- Outputs change only on CLK120 edge where ENABLE40 == 2, so stable when ENABLE40 == 0 (the trigger's sampling phase).
- START to first raised sample: first tick after START, i.e. 1–3 CLK120 cycles.
- Pulse k (0-based) first rising sample at tick T0 + k·eff_gap.
- Burst length: N_PULSES·eff_gap ticks; DONE at tick after final gap expires, outputs return to BASELINE same tick.
- START in same cycle as DONE: ignored (BUSY still 1 that cycle... DONE cycle BUSY = 0 after edge; START accepted from the following cycle).

## Configuration
- MOPS_PULSE_GEN_JITTER_EN defined: 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1 on RESET) advances every tick; at each gap reload, eff_gap += LFSR[1:0] (0–3 extra samples). Randomises pulse spacing for MoPS occupancy-window testing.
- Undefined: no LFSR; spacing exactly eff_gap; fully deterministic.

## Test plan
- Reset then idle, BASELINE=50, PMT_MASK=7 -> ADC0..2 = 0 until first tick, then 50; BUSY=0, DONE=0.
- BASELINE=50, STEP_AMP=20, RISE_SAMPLES=3, DECAY_SHIFT=0, N_PULSES=2, GAP=10, mask=3'b101 -> ADC0/ADC2 per tick: 70,90,110,50×7,70,90,110,50×7; ADC1 constant 50; DONE once after 20 ticks.
- DECAY_SHIFT=1, STEP_AMP=64, RISE=1, GAP=20, N=1 -> 64,32,16,8,4,2,1,0 above baseline; DONE at tick 20.
- Saturation: BASELINE=4000, STEP_AMP=2000, RISE=4 -> outputs clamp at 4095, no wrap.
- GAP=2, RISE=5 -> effective spacing 6 ticks; N_PULSES=0 -> DONE one tick after START, BUSY stays 0.
- RESET asserted mid-RISE -> next cycle outputs 0, BUSY=0; START during BUSY ignored (pulse count unchanged).
